woz_sd_arbiter: RTL and testbench

WOZ_SD_ARBITER -- requirements
Module: woz_sd_arbiter

---
 rtl/woz_arb_pkg.sv | 20 ++
 rtl/woz_rr_pick.sv | 39 +++
 rtl/woz_sd_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_woz_sd_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/woz_arb_pkg.sv
// Shared types and defaults for the WOZ track-buffer SD arbiter.
// Holds the FSM state enum, default parameters and an index-width helper.
package woz_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    XFER     = 2'd2
  } arb_state_e;

  localparam int NUM_REQ_DEFAULT = 2;
  localparam int TIMEOUT_DEFAULT = 65535;

  // Width of a requester index; never zero so a single requester still
  // gets a usable one-bit grant.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/woz_rr_pick.sv
// Combinational round-robin picker: request vector + last winner index in,
// next winner index out. Search starts at (last+1) mod N.
// Ports: req_i (N), last_i (GW) -> idx_o (GW), valid_o.
module woz_rr_pick
  import woz_arb_pkg::*;
#(
  parameter  int N  = NUM_REQ_DEFAULT,
  localparam int GW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [GW-1:0] last_i,
  output logic [GW-1:0] idx_o,
  output logic          valid_o
);

  // Each requester gets a rotation distance from last; the nearest
  // active one wins. last itself has distance N, the lowest priority.
  always_comb begin
    int d;
    int best;
    idx_o   = '0;
    valid_o = 1'b0;
    best    = N + 1;
    d       = 0;
    for (int j = 0; j < N; j++) begin
      if (j > int'(last_i)) begin
        d = j - int'(last_i);
      end else begin
        d = j - int'(last_i) + N;
      end
      if (req_i[j] && (d < best)) begin
        best    = d;
        idx_o   = GW'(j);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/woz_sd_arbiter.sv
// Shares one SD block port among NUM_REQ track-buffer requesters.
// Round-robin grant, latched LBA, ack/byte strobes routed to the winner.
// Ports: clk, reset (sync, high); req_lba/req_rd/req_wr/req_buff_din in;
//   req_ack/req_buff_wr out; sd_lba/sd_rd/sd_wr/sd_buff_din out;
//   sd_ack/sd_buff_wr in; grant, busy, timeout out.
// Optional: WOZ_ARB_TIMEOUT_EN adds a WAIT_ACK watchdog of
//   TIMEOUT_CYCLES; otherwise timeout is tied low.
module woz_sd_arbiter
  import woz_arb_pkg::*;
#(
  parameter  int NUM_REQ        = NUM_REQ_DEFAULT,
  parameter  int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  localparam int GW             = idx_w(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [32*NUM_REQ-1:0]  req_lba,
  input  logic [NUM_REQ-1:0]     req_rd,
  input  logic [NUM_REQ-1:0]     req_wr,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic [NUM_REQ-1:0]     req_buff_wr,
  input  logic [8*NUM_REQ-1:0]   req_buff_din,
  output logic [31:0]            sd_lba,
  output logic                   sd_rd,
  output logic                   sd_wr,
  input  logic                   sd_ack,
  input  logic                   sd_buff_wr,
  output logic [7:0]             sd_buff_din,
  output logic [GW-1:0]          grant,
  output logic                   busy,
  output logic                   timeout
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_e    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;
  logic [31:0]   lba_q, lba_d;
  logic          sd_rd_q, sd_rd_d;
  logic          sd_wr_q, sd_wr_d;
  logic          old_ack_q;

  logic [31:0]   lba_a [NUM_REQ];
  logic [7:0]    din_a [NUM_REQ];

  logic [GW-1:0] pick_idx;
  logic          pick_valid;
  logic          wd_fire;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign lba_a[i] = req_lba[32*i +: 32];
    assign din_a[i] = req_buff_din[8*i +: 8];
  end

  woz_rr_pick #(
    .N(NUM_REQ)
  ) u_pick (
    .req_i  (req_rd | req_wr),
    .last_i (last_q),
    .idx_o  (pick_idx),
    .valid_o(pick_valid)
  );

`ifdef WOZ_ARB_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDW-1:0] wd_q, wd_d;
  logic           timeout_q, timeout_d;

  // wd_q holds the number of WAIT_ACK cycles already elapsed, so the
  // watchdog fires on the edge that ends cycle TIMEOUT_CYCLES.
  assign wd_fire = (wd_q == WDW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wd_d      = '0;
    timeout_d = 1'b0;
    if (state_q == WAIT_ACK && !sd_ack) begin
      if (wd_fire) begin
        timeout_d = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign wd_fire = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    lba_d   = lba_q;
    sd_rd_d = sd_rd_q;
    sd_wr_d = sd_wr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          lba_d   = lba_a[pick_idx];
          // A read wins over a write from the same requester; the
          // write stays pending for a later round.
          sd_rd_d = req_rd[pick_idx];
          sd_wr_d = ~req_rd[pick_idx];
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (sd_ack) begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          state_d = XFER;
        end else if (wd_fire) begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      XFER: begin
        if (old_ack_q && !sd_ack) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        sd_rd_d = 1'b0;
        sd_wr_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      last_q    <= GW'(NUM_REQ - 1);
      lba_q     <= '0;
      sd_rd_q   <= 1'b0;
      sd_wr_q   <= 1'b0;
      old_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      lba_q     <= lba_d;
      sd_rd_q   <= sd_rd_d;
      sd_wr_q   <= sd_wr_d;
      old_ack_q <= sd_ack;
    end
  end

  assign busy   = (state_q != IDLE);
  assign grant  = grant_q;
  assign sd_lba = lba_q;
  assign sd_rd  = sd_rd_q;
  assign sd_wr  = sd_wr_q;

  // Routing is gated by busy so a reset silences the requester at once.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_route
    assign req_ack[i]     = busy && (grant_q == GW'(i)) && sd_ack;
    assign req_buff_wr[i] = busy && (grant_q == GW'(i)) && sd_buff_wr;
  end

  assign sd_buff_din = busy ? din_a[grant_q] : 8'h00;

endmodule

// File: tb/tb_woz_sd_arbiter.sv
// Scoreboard bench for woz_sd_arbiter (NUM_REQ=2).
// Stimulus queues expected grants; a monitor checks each host strobe.
module tb_woz_sd_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] req_lba;
  logic [1:0]  req_rd;
  logic [1:0]  req_wr;
  logic [1:0]  req_ack;
  logic [1:0]  req_buff_wr;
  logic [15:0] req_buff_din;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din;
  logic [0:0]  grant;
  logic        busy;
  logic        timeout;

  always #5 clk = ~clk;

  woz_sd_arbiter #(
    .NUM_REQ(2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_lba     (req_lba),
    .req_rd      (req_rd),
    .req_wr      (req_wr),
    .req_ack     (req_ack),
    .req_buff_wr (req_buff_wr),
    .req_buff_din(req_buff_din),
    .sd_lba      (sd_lba),
    .sd_rd       (sd_rd),
    .sd_wr       (sd_wr),
    .sd_ack      (sd_ack),
    .sd_buff_wr  (sd_buff_wr),
    .sd_buff_din (sd_buff_din),
    .grant       (grant),
    .busy        (busy),
    .timeout     (timeout)
  );

  typedef struct packed {
    logic        rd;
    logic [0:0]  g;
    logic [31:0] lba;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_total = 0;
  int   n_pass  = 0;
  int   bw0 = 0;
  int   bw1 = 0;
  int   ack0 = 0;
  logic prev_strobe = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  always @(negedge clk) begin
    if ((sd_rd | sd_wr) && !prev_strobe) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 32'(grant), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("strobe_rd", 32'(sd_rd), 32'(e.rd));
        check("strobe_wr", 32'(sd_wr), 32'(!e.rd));
        check("strobe_grant", 32'(grant), 32'(e.g));
        check("strobe_lba", sd_lba, e.lba);
      end
    end
    prev_strobe <= sd_rd | sd_wr;
    if (req_buff_wr[0]) bw0 <= bw0 + 1;
    if (req_buff_wr[1]) bw1 <= bw1 + 1;
    if (req_ack[0]) ack0 <= ack0 + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic wait_strobe(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (!(sd_rd | sd_wr) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({name, "_strobe_seen"}, 32'(sd_rd | sd_wr), 32'd1);
  endtask

  // Host side: wait for a strobe, ack and stream nbytes, then release.
  task automatic host_xfer(input string name, input int nbytes,
                           input logic [1:0] drop_rd,
                           input logic [1:0] drop_wr,
                           input logic [31:0] exp_lba,
                           input logic [7:0] exp_din);
    wait_strobe(name);
    @(posedge clk);
    #1;
    sd_ack     = 1'b1;
    sd_buff_wr = 1'b1;
    req_rd     = req_rd & ~drop_rd;
    req_wr     = req_wr & ~drop_wr;
    tick(nbytes);
    check({name, "_lba_stable"}, sd_lba, exp_lba);
    check({name, "_buff_din"}, 32'(sd_buff_din), 32'(exp_din));
    sd_ack     = 1'b0;
    sd_buff_wr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({name, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: got running, required finished");
    $fatal(1);
  end

  initial begin
    int cnt;
    reset        = 1'b1;
    req_lba      = '0;
    req_rd       = '0;
    req_wr       = '0;
    req_buff_din = 16'hB4C3;
    sd_ack       = 1'b0;
    sd_buff_wr   = 1'b0;
    tick(2);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sd_rd", 32'(sd_rd), 32'd0);
    check("rst_sd_wr", 32'(sd_wr), 32'd0);
    check("rst_sd_lba", sd_lba, 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_din", 32'(sd_buff_din), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick(1);

    // Single read from requester 1
    req_lba[63:32] = 32'h1A0;
    req_rd[1]      = 1'b1;
    exp_q.push_back('{rd: 1'b1, g: 1'b1, lba: 32'h1A0});
    bw0 = 0;
    bw1 = 0;
    @(posedge clk);
    @(negedge clk);
    check("single_latency", 32'(sd_rd), 32'd1);
    host_xfer("single", 512, 2'b10, 2'b00, 32'h1A0, 8'hB4);
    check("single_bw1", bw1, 512);
    check("single_bw0", bw0, 0);

    // Contention from reset: 0, 1, 0
    do_reset();
    req_lba = {32'h200, 32'h100};
    req_rd  = 2'b11;
    exp_q.push_back('{rd: 1'b1, g: 1'b0, lba: 32'h100});
    exp_q.push_back('{rd: 1'b1, g: 1'b1, lba: 32'h200});
    exp_q.push_back('{rd: 1'b1, g: 1'b0, lba: 32'h100});
    host_xfer("rr_a", 4, 2'b00, 2'b00, 32'h100, 8'hC3);
    host_xfer("rr_b", 4, 2'b00, 2'b00, 32'h200, 8'hB4);
    host_xfer("rr_c", 4, 2'b11, 2'b00, 32'h100, 8'hC3);
    tick(4);
    check("rr_queue_drained", exp_q.size(), 0);

    // Requester 0 drops before ack
    do_reset();
    req_lba[31:0] = 32'h55;
    req_rd        = 2'b01;
    exp_q.push_back('{rd: 1'b1, g: 1'b0, lba: 32'h55});
    tick(2);
    req_rd        = 2'b00;
    req_lba[31:0] = 32'hDEAD;
    ack0 = 0;
    host_xfer("drop", 3, 2'b00, 2'b00, 32'h55, 8'hC3);
    check("drop_ack0", ack0, 3);
    tick(3);
    check("drop_stays_idle", 32'(busy), 32'd0);

    // Read and write together on requester 0
    do_reset();
    req_lba[31:0] = 32'h77;
    req_rd        = 2'b01;
    req_wr        = 2'b01;
    exp_q.push_back('{rd: 1'b1, g: 1'b0, lba: 32'h77});
    exp_q.push_back('{rd: 1'b0, g: 1'b0, lba: 32'h77});
    host_xfer("rdwr_rd", 2, 2'b01, 2'b00, 32'h77, 8'hC3);
    host_xfer("rdwr_wr", 2, 2'b00, 2'b01, 32'h77, 8'hC3);
    check("rdwr_din_idle", 32'(sd_buff_din), 32'd0);

    // Reset during transfer at byte 100
    do_reset();
    req_lba[63:32] = 32'h300;
    req_rd         = 2'b10;
    exp_q.push_back('{rd: 1'b1, g: 1'b1, lba: 32'h300});
    wait_strobe("rstx");
    @(posedge clk);
    #1;
    sd_ack     = 1'b1;
    sd_buff_wr = 1'b1;
    tick(100);
    check("rstx_busy_before", 32'(busy), 32'd1);
    reset  = 1'b1;
    req_rd = 2'b00;
    @(posedge clk);
    @(negedge clk);
    check("rstx_busy", 32'(busy), 32'd0);
    check("rstx_buff_wr", 32'(req_buff_wr), 32'd0);
    check("rstx_ack", 32'(req_ack), 32'd0);
    check("rstx_sd_rd", 32'(sd_rd), 32'd0);
    @(posedge clk);
    #1;
    sd_ack     = 1'b0;
    sd_buff_wr = 1'b0;
    reset      = 1'b0;
    tick(3);
    check("rstx_idle_after", 32'(busy), 32'd0);

`ifdef WOZ_ARB_TIMEOUT_EN
    // Watchdog: requester 0 never acked, requester 1 then served
    do_reset();
    req_lba = {32'h20, 32'h10};
    req_rd  = 2'b11;
    exp_q.push_back('{rd: 1'b1, g: 1'b0, lba: 32'h10});
    exp_q.push_back('{rd: 1'b1, g: 1'b1, lba: 32'h20});
    wait_strobe("to");
    cnt = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!sd_rd) break;
      cnt++;
    end
    check("to_wait_cycles", cnt, 16);
    check("to_pulse", 32'(timeout), 32'd1);
    host_xfer("to_next", 2, 2'b11, 2'b00, 32'h20, 8'hB4);
`else
    cnt = 0;
    check("no_timeout", 32'(timeout), 32'(cnt));
`endif

    tick(3);
    check("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
